// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: tear-free double-buffered value,
// fixed-dwell digit slots with an anode-off gap, optional leading-zero blanking.
//
// state | meaning
// IDLE  | scan disabled, anodes off, code blank, active tracks pending
// BLANK | start of slot, anodes off while the new code settles
// SHOW  | anode of digit_idx driven low for the rest of the slot
module display_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*N_DIGITS-1:0]         digits_in,
    input  logic                          lzb_in,
    output logic [3:0]                    bcd_out,
    output logic [N_DIGITS-1:0]           an_out,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
    output logic                          frame_tick
);
    localparam int IW = $clog2(N_DIGITS);
    localparam int CW = $clog2(SLOT_CYCLES + 1);
    localparam logic [IW-1:0] LAST       = IW'(N_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(SLOT_CYCLES - BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx_nxt;
    logic [N_DIGITS-1:0]   an_nxt;
    logic [3:0]            bcd_nxt;
    logic                  tick_nxt;
    logic                  act_copy;

    logic [4*N_DIGITS-1:0] pend, act, src;
    logic                  pend_lzb, lzb, src_lzb;
    logic                  wrap, all_zero;
    logic [IW-1:0]         blank_idx;
    logic [3:0]            code;

    // Index and data source for the next BLANK entry; a frame boundary
    // reads pending directly since active is being loaded on that same edge.
    assign wrap      = (state == IDLE) || (digit_idx == LAST);
    assign blank_idx = wrap ? '0 : digit_idx + 1'b1;

    always_comb begin
        src      = wrap ? pend : act;
        src_lzb  = wrap ? pend_lzb : lzb;
        code     = src[4*blank_idx +: 4];
        all_zero = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            if (i >= int'(blank_idx))
                all_zero = all_zero & (src[4*i +: 4] == 4'h0);
        end
        if (src_lzb && (blank_idx != '0) && all_zero)
            code = 4'hF;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = digit_idx;
        an_nxt    = an_out;
        bcd_nxt   = bcd_out;
        tick_nxt  = 1'b0;
        act_copy  = (state == IDLE);
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            an_nxt    = '1;
            bcd_nxt   = 4'hF;
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == '0) begin
                        state_nxt = SHOW;
                        cnt_nxt   = SHOW_LOAD;
                        an_nxt    = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << digit_idx);
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt != '0)
                        cnt_nxt = cnt - 1'b1;
                end
                default: ;
            endcase
            if (state == IDLE || (state == SHOW && cnt == '0)) begin
                state_nxt = BLANK;
                cnt_nxt   = BLANK_LOAD;
                idx_nxt   = blank_idx;
                an_nxt    = '1;
                bcd_nxt   = code;
                tick_nxt  = wrap;
                act_copy  = wrap;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            digit_idx  <= '0;
            an_out     <= '1;
            bcd_out    <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            digit_idx  <= idx_nxt;
            an_out     <= an_nxt;
            bcd_out    <= bcd_nxt;
            frame_tick <= tick_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            pend_lzb <= 1'b0;
            act      <= '0;
            lzb      <= 1'b0;
        end else begin
            if (load) begin
                pend     <= digits_in;
                pend_lzb <= lzb_in;
            end
            if (act_copy) begin
                act <= pend;
                lzb <= pend_lzb;
            end
        end
    end
endmodule
